// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and pointer width.
package fifo_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  // Pointer width for a given memory address size (one extra wrap bit).
  function automatic int unsigned ptr_width(input int unsigned addr_size);
    return addr_size + 1;
  endfunction

  // Binary to reflected Gray code; callers zero-extend narrower values.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary by prefix XOR from the MSB down.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync2.sv
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
module fifo_sync2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Capture stage then resolve stage; only sync_q is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: synchronises the writer pointer, owns the
// read pointer, flags empty and presents words through a registered
// valid/ready output stage.
// Optional macro FIFO_RD_LEVEL_EN adds r_level / r_almost_empty outputs.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_SIZE  = 3
`ifdef FIFO_RD_LEVEL_EN
  ,
  parameter int unsigned AE_THRESH  = 1
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_SIZE:0]    w_gptr,
  output logic [ADDR_SIZE:0]    r_gptr,
  output logic [ADDR_SIZE-1:0]  r_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  r_empty
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ADDR_SIZE:0]    r_level,
  output logic                  r_almost_empty
`endif
);

  localparam int unsigned PW = ptr_width(ADDR_SIZE);

  logic [PW-1:0]         wq2;
  logic [PW-1:0]         rbin_q, rbin_d;
  logic [PW-1:0]         r_gptr_q, r_gptr_d;
  logic                  r_empty_q, r_empty_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  fetch_c;

  // Writer pointer enters this domain only through the synchroniser.
  fifo_sync2 #(
    .WIDTH (PW)
  ) u_wptr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (w_gptr),
    .q     (wq2)
  );

  // Fetch when a word is available and the output register is free or draining.
  always_comb begin
    fetch_c     = !r_empty_q && (!out_valid_q || out_ready);
    rbin_d      = rbin_q + PW'(fetch_c);
    r_gptr_d    = PW'(bin2gray(gray_word_t'(rbin_d)));
    // Compare against the next pointer so the last fetch sets empty on its own edge.
    r_empty_d   = (r_gptr_d == wq2);
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (fetch_c) begin
      out_data_d  = mem_data;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pointer, empty flag and output stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin_q      <= '0;
      r_gptr_q    <= '0;
      r_empty_q   <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rbin_q      <= rbin_d;
      r_gptr_q    <= r_gptr_d;
      r_empty_q   <= r_empty_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign r_gptr    = r_gptr_q;
  assign r_addr    = rbin_q[ADDR_SIZE-1:0];
  assign r_empty   = r_empty_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

`ifdef FIFO_RD_LEVEL_EN
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] r_level_q, r_level_d;
  logic          r_ae_q, r_ae_d;

  // Unfetched-word count from the synchronised writer pointer (modular).
  always_comb begin
    wbin_s    = PW'(gray2bin(gray_word_t'(wq2)));
    r_level_d = wbin_s - rbin_d;
    r_ae_d    = (r_level_d <= PW'(AE_THRESH));
  end

  // Level and almost-empty registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_q <= '0;
      r_ae_q    <= 1'b1;
    end else begin
      r_level_q <= r_level_d;
      r_ae_q    <= r_ae_d;
    end
  end

  assign r_level        = r_level_q;
  assign r_almost_empty = r_ae_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl; models the writer and fifo_mem.
// Build with FIFO_RD_LEVEL_EN defined to also check r_level / r_almost_empty.
module tb_fifo_rd_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AS = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AS:0]   w_gptr;
  logic [AS:0]   r_gptr;
  logic [AS-1:0] r_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          r_empty;
`ifdef FIFO_RD_LEVEL_EN
  logic [AS:0]   r_level;
  logic          r_almost_empty;
`endif

  logic [DW-1:0] mem [DEPTH];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: counts of words written / fetched, writer count seen
  // through two stages of synchronisation, output register contents.
  int            wr_cnt;
  int            m_rd;
  int            m_s1, m_s2;
  bit            m_empty;
  bit            m_ov;
  logic [DW-1:0] m_od;
  int            m_level;
  logic [DW-1:0] wq [$];

  always #5 clk = ~clk;

  assign mem_data = mem[r_addr];

  fifo_rd_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_SIZE  (AS)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .AE_THRESH  (1)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_gptr    (w_gptr),
    .r_gptr    (r_gptr),
    .r_addr    (r_addr),
    .mem_data  (mem_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r_empty   (r_empty)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .r_level        (r_level),
    .r_almost_empty (r_almost_empty)
`endif
  );

  function automatic logic [AS:0] gray_of(input int cnt);
    logic [AS:0] b;
    b = cnt[AS:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("r_empty",   32'(r_empty),   32'(m_empty));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data",  32'(out_data),  32'(m_od));
    chk("r_gptr",    32'(r_gptr),    32'(gray_of(m_rd)));
    chk("r_addr",    32'(r_addr),    32'(m_rd % DEPTH));
`ifdef FIFO_RD_LEVEL_EN
    chk("r_level",   32'(r_level),   32'(m_level));
    chk("r_ae",      32'(r_almost_empty), 32'(m_level <= 1));
`endif
  endtask

  task automatic model_reset();
    wr_cnt  = 0;
    m_rd    = 0;
    m_s1    = 0;
    m_s2    = 0;
    m_empty = 1'b1;
    m_ov    = 1'b0;
    m_od    = '0;
    m_level = 0;
    wq.delete();
    w_gptr  = '0;
  endtask

  // Writer side: store a word and advance the writer Gray pointer.
  task automatic write_word(input logic [DW-1:0] v);
    mem[wr_cnt % DEPTH] = v;
    wq.push_back(v);
    wr_cnt++;
    w_gptr = gray_of(wr_cnt);
  endtask

  function automatic bit can_write();
    return (wr_cnt - m_rd) < DEPTH;
  endfunction

  // One clock: advance the model on the pre-edge inputs, then compare.
  task automatic step();
    bit f;
    int s2_old;
    f      = !m_empty && (!m_ov || out_ready);
    s2_old = m_s2;
    if (f) begin
      m_od = wq[m_rd];
      m_ov = 1'b1;
      m_rd++;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    m_s2    = m_s1;
    m_s1    = wr_cnt;
    m_empty = (m_rd == s2_old);
    m_level = s2_old - m_rd;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_empty", 32'(r_empty),   32'd1);
    chk("rst_gptr",  32'(r_gptr),    32'd0);
    chk("rst_addr",  32'(r_addr),    32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    out_ready = 1'b0;
    w_gptr    = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    model_reset();
    #2;

    // Reset and idle with toggling out_ready.
    do_reset();
    check_all();
    for (int i = 0; i < 8; i++) begin
      out_ready = i[0];
      step();
    end

    // Single word: latency and consumption.
    out_ready = 1'b0;
    write_word(8'hA5);
    step(); step();
    chk("lat_e2_empty", 32'(r_empty), 32'd1);
    step();
    chk("lat_e3_empty", 32'(r_empty), 32'd0);
    chk("lat_e3_valid", 32'(out_valid), 32'd0);
    step();
    chk("lat_e4_valid", 32'(out_valid), 32'd1);
    chk("lat_e4_data",  32'(out_data),  32'hA5);
    out_ready = 1'b1;
    step();
    chk("cons_valid", 32'(out_valid), 32'd0);
    chk("cons_empty", 32'(r_empty),   32'd1);
    chk("cons_gptr",  32'(r_gptr),    32'd1);

    // Fill the whole memory while stalled, then drain back to back.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      write_word(8'(8'h10 + i));
      step();
    end
    for (int i = 0; i < 4; i++) step();
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_data",  32'(out_data),  32'h10);
    chk("stall_addr",  32'(r_addr),    32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i < 7) chk("drain_data", 32'(out_data), 32'(8'h11 + i));
    end
    chk("drain_gptr",  32'(r_gptr),    32'hC);
    chk("drain_empty", 32'(r_empty),   32'd1);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Twenty words streamed so the pointer MSB toggles and wraps.
    begin
      int sent;
      sent = 0;
      for (int c = 0; c < 80; c++) begin
        if (sent < 20 && can_write()) begin
          write_word(8'($urandom));
          sent++;
        end
        step();
      end
      chk("wrap_count", 32'(m_rd), 32'd28);
    end

    // Level check: five words at once, stalled then drained.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) write_word(8'(8'h60 + i));
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();

    // Randomised traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (can_write() && $urandom_range(0, 2) != 0) write_word(8'($urandom));
      step();
    end

    // Reset mid-burst, then resume from address 0.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) write_word(8'(8'hC0 + i));
    for (int i = 0; i < 5; i++) step();
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      write_word(8'(8'hE0 + i));
      step();
    end
    for (int i = 0; i < 6; i++) step();
    chk("post_rst_rd", 32'(m_rd), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller of the async FIFO, pairing with the write-side pointer logic and the shared fifo_mem.
- Synchronises the writer's Gray pointer into the read clock domain.
- Maintains the read pointer and drives the memory read address.
- Flags empty.
- Presents data through a registered valid/ready output stage, so the memory's asynchronous read path never reaches the consumer combinationally.

Parameters:
DATA_WIDTH, 8, width of a FIFO word
ADDR_SIZE, 3, memory address bits; depth = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits
AE_THRESH, 1, almost-empty threshold (used only with FIFO_RD_LEVEL_EN)

Ports:
clk  in  1  read-domain clock
rst_n  in  1  asynchronous active-low reset
w_gptr  in  ADDR_SIZE+1  writer Gray pointer (writer clock domain)
r_gptr  out  ADDR_SIZE+1  read Gray pointer, registered, to writer-side synchroniser
r_addr  out  ADDR_SIZE  read address to fifo_mem
mem_data  in  DATA_WIDTH  fifo_mem asynchronous read data
out_data  out  DATA_WIDTH  registered output word
out_valid  out  1  out_data holds an unconsumed word
out_ready  in  1  consumer accepts; transfer = out_valid & out_ready
r_empty  out  1  memory holds no unfetched word (registered)
r_level  out  ADDR_SIZE+1  unfetched words in memory (FIFO_RD_LEVEL_EN only)
r_almost_empty  out  1  r_level <= AE_THRESH (FIFO_RD_LEVEL_EN only)

Behaviour:
- Reset (async assert, synchronous release), all values 0 except r_empty:
  - wq1, wq2, rbin, r_gptr, out_data, out_valid = 0
  - r_empty = 1
  - r_level = 0, r_almost_empty = 1
- Synchroniser: wq1 <= w_gptr, wq2 <= wq1. wq2 is the only path by which write-domain data is used.
- fetch = !r_empty & (!out_valid | out_ready).
- Read pointer:
  - rbin_next = rbin + fetch, wrapping modulo 2**(ADDR_SIZE+1).
  - r_gptr_next = bin2gray(rbin_next).
  - Both registered.
  - r_addr = rbin[ADDR_SIZE-1:0].
- Empty: r_empty <= (r_gptr_next == wq2). Computed from the next pointer, so the last fetch asserts r_empty on the same edge.
- Output stage:
  - on fetch: out_data <= mem_data, out_valid <= 1.
  - else if out_ready: out_valid <= 0.
  - else: hold.
  - out_data never changes while out_valid & !out_ready.
- Latency, from the w_gptr change to first availability:
  - edge 1: wq1 updates.
  - edge 2: wq2 updates.
  - edge 3: r_empty = 0.
  - edge 4: out_valid = 1.
- Throughput: one word per clk while out_ready = 1 and data is available. No bubble between back-to-back words.
- Simultaneous transfer and fetch: the output register is reloaded in the same cycle and out_valid stays 1.
- Wrap-around: the MSB of the pointer toggles every 2**ADDR_SIZE reads. Empty is equality of all ADDR_SIZE+1 bits, so a full memory never reads as empty.
- Mid-operation reset:
  - pointers, output stage and r_empty return to reset values immediately.
  - out_valid drops asynchronously.
  - Both FIFO sides must be reset together; a one-sided reset is unsupported.
- Stale wq2 makes empty pessimistic only; the block never reads an unwritten location.

Optional Feature:
Macro FIFO_RD_LEVEL_EN.
- Defined:
  - wbin_s = gray2bin(wq2).
  - r_level <= wbin_s - rbin_next (ADDR_SIZE+1 bits, modular).
  - r_almost_empty <= (wbin_s - rbin_next) <= AE_THRESH.
  - Both ports exist.
- Undefined: r_level and r_almost_empty ports and their logic are absent; the port list omits them.

Decomposition:
- Package fifo_pkg:
  - bin2gray and gray2bin functions.
  - Pointer-width localparam helper.
  - Shared with the write side.
- Sub-module fifo_sync2: parameterised-width two-flop synchroniser, clk/rst_n, reset 0. Reused by the write side for r_gptr.

Test Plan (DATA_WIDTH=8, ADDR_SIZE=3; the bench models the writer and fifo_mem):
- Reset, then w_gptr held 0 -> r_empty=1, out_valid=0, r_addr=0, r_gptr=0 indefinitely; out_ready toggling changes nothing.
- Write 0xA5, so w_gptr 0->1 -> r_empty=0 at clk edge 3, out_valid=1 with out_data=0xA5 at edge 4.
- Consume with out_ready=1 -> next edge: out_valid=0, r_empty=1, r_gptr=1.
- Write 8 words 0x10..0x17 (w_gptr=bin2gray(8)=0xC) with out_ready=0:
  - one fetch occurs, then the block stalls; out_data holds 0x10.
  - Raise out_ready -> 0x10..0x17 emerge on consecutive cycles.
  - r_gptr ends at 0xC and r_empty=1.
- Run 20 words through so pointers wrap past 15->0 -> data order intact, with no false empty or false non-empty at the MSB toggle.
- FIFO_RD_LEVEL_EN with AE_THRESH=1 and 5 words written -> r_level=5 then decrements per fetch; r_almost_empty=1 once r_level <= 1.
- Assert rst_n mid-burst -> out_valid=0 and r_empty=1 asynchronously; after release, read resumes from r_addr=0.
